bexkat2_prefetch: RTL

Instruction prefetch buffer between the bexkat2 core's instruction bus master and instruction memory. It fetches sequential words ahead of the core into a small FIFO. Sequential fetches are acknowledged with zero wait states from the buffer. A non-sequential request flushes the buffer and restarts the stream at the new address. Both sides are classic Wishbone with a single outstanding transfer; the core's side is read-only with all byte lanes selected.

---
 rtl/bexkat2_prefetch.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bexkat2_prefetch.sv
// bexkat2_prefetch
//
// Instruction prefetch buffer between the bexkat2 core's instruction bus
// master and instruction memory. Sequential words are fetched ahead of the
// core into a small FIFO. Requests that match the oldest buffered word are
// acknowledged in the same cycle. Any other request flushes the FIFO and
// restarts the stream at the new address.
//
// Parameters:
//   DEPTH    number of buffered words (power of two, 2..16)
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-low reset
//   cpu_cyc  core fetch request, held until cpu_ack
//   cpu_adr  core fetch address (bits [1:0] ignored)
//   cpu_ack  fetch complete, cpu_dat valid (combinational)
//   cpu_dat  instruction word (combinational)
//   inv      single-cycle pulse: invalidate buffer and stream
//   mem_cyc  memory cycle (registered)
//   mem_stb  memory strobe, identical to mem_cyc
//   mem_adr  memory word address, bits [1:0] always 0 (registered)
//   mem_ack  memory acknowledge
//   mem_dat  memory read data

module bexkat2_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_cyc,
  input  logic [31:0] cpu_adr,
  output logic        cpu_ack,
  output logic [31:0] cpu_dat,
  input  logic        inv,
  output logic        mem_cyc,
  output logic        mem_stb,
  output logic [31:0] mem_adr,
  input  logic        mem_ack,
  input  logic [31:0] mem_dat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic            valid_reg, valid_next;
  logic [29:0]     head_adr_reg, head_adr_next;    // word address of oldest entry
  logic [29:0]     fetch_adr_reg, fetch_adr_next;  // next word address to request
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic            discard_reg, discard_next;
  logic [29:0]     mem_adr_reg, mem_adr_next;

  logic [31:0]     buf_mem [DEPTH];

  logic            busy;
  logic            addr_match;
  logic            hit;
  logic            miss;
  logic            flush;
  logic            push;
  logic            pop;
  logic            unused_adr_bits;

  assign unused_adr_bits = ^cpu_adr[1:0];

  assign busy       = (state_reg == FETCH);
  assign addr_match = (cpu_adr[31:2] == head_adr_reg);

  // inv outranks everything else this cycle, so hit and miss are both
  // suppressed while it is asserted.
  assign hit   = cpu_cyc && !inv && valid_reg && addr_match && (count_reg != '0);
  assign miss  = cpu_cyc && !inv && !(valid_reg && addr_match);
  assign flush = inv || miss;

  // A fill is written only if it belongs to the current stream and the
  // stream is not being torn down in the same cycle.
  assign push = busy && mem_ack && !discard_reg && !flush;
  assign pop  = hit;

  assign cpu_ack = hit;
  assign cpu_dat = buf_mem[rd_ptr_reg];

  assign mem_cyc = busy;
  assign mem_stb = busy;
  assign mem_adr = {mem_adr_reg, 2'b00};

  always_comb begin
    state_next     = state_reg;
    valid_next     = valid_reg;
    head_adr_next  = head_adr_reg;
    fetch_adr_next = fetch_adr_reg;
    count_next     = count_reg;
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    discard_next   = discard_reg;
    mem_adr_next   = mem_adr_reg;

    if (flush) begin
      count_next  = '0;
      rd_ptr_next = wr_ptr_reg;
      valid_next  = miss;
      if (miss) begin
        head_adr_next  = cpu_adr[31:2];
        fetch_adr_next = cpu_adr[31:2];
      end
      // A cycle still waiting for its ack must have its data dropped; one
      // that completes right now is simply ignored.
      discard_next = busy && !mem_ack;
    end else begin
      if (pop) begin
        rd_ptr_next   = rd_ptr_reg + PW'(1);
        head_adr_next = head_adr_reg + 30'd1;
      end
      if (push) begin
        wr_ptr_next    = wr_ptr_reg + PW'(1);
        fetch_adr_next = fetch_adr_reg + 30'd1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
      if (busy && mem_ack && discard_reg) begin
        discard_next = 1'b0;
      end
    end

    case (state_reg)
      IDLE: begin
        // Only IDLE can start a cycle, so busy is 0 here and the room
        // check reduces to count < DEPTH.
        if (valid_reg && !flush && (count_reg < CW'(DEPTH))) begin
          state_next   = FETCH;
          mem_adr_next = fetch_adr_reg;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      valid_reg     <= 1'b0;
      head_adr_reg  <= '0;
      fetch_adr_reg <= '0;
      count_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      discard_reg   <= 1'b0;
      mem_adr_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      valid_reg     <= valid_next;
      head_adr_reg  <= head_adr_next;
      fetch_adr_reg <= fetch_adr_next;
      count_reg     <= count_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      discard_reg   <= discard_next;
      mem_adr_reg   <= mem_adr_next;
    end
  end

  // Buffer storage carries no reset; its contents are only visible after
  // a push has made them valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_mem[wr_ptr_reg] <= mem_dat;
    end
  end

endmodule
